// File: rtl/fifo2gmii48_pkg.sv
// fifo2gmii48_pkg: shared state encoding, frame geometry and CRC-32 constants for the GMII framer
package fifo2gmii48_pkg;
    typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PAY, FCS, IFG} state_t;
    localparam int PREAMBLE_LEN = 7;
    localparam int HDR_LEN = 14;
    localparam int FCS_LEN = 4;
    localparam int IFG_LEN = 12;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide reflected IEEE 802.3 CRC-32 register, LSB of each byte first
module crc32_d8
    import fifo2gmii48_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        calc,
    input  logic [7:0]  d,
    output logic [31:0] crc
);
    logic [31:0] nxt;
    always_comb begin
        nxt = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            nxt = nxt[0] ? (nxt >> 1) ^ CRC_POLY_REFL : nxt >> 1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (calc)
            crc <= nxt;
    end
endmodule

// File: rtl/fifo2gmii48.sv
// fifo2gmii48: frames WORDS 48-bit pixel words from a FWFT FIFO into one raw Ethernet frame on GMII
module fifo2gmii48
    import fifo2gmii48_pkg::*;
#(
    parameter int          WORDS     = 8,
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0000_5E00_FACE,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        i_clk_125M,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [47:0] i_fifo_dout,
    input  logic        i_fifo_empty,
    input  logic [11:0] i_fifo_count,
    output logic        o_fifo_rd_en,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        tx_er,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);
    localparam int PAY_LEN = 6 * WORDS;
    localparam int CW = $clog2(PAY_LEN);
    localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};

    state_t state, nstate;
    logic [CW-1:0] cnt, ncnt, lim;
    logic [2:0] bw, nbw;
    logic [7:0] nbyte;
    logic [31:0] crc;
    logic armed, err, nerr, start;

    // Everything is computed for the byte about to be registered, so the outputs line up with state.
    // IFG holds one cycle short because the IDLE evaluation cycle completes the 12-cycle gap.
    always_comb begin
        lim = state == PRE ? CW'(PREAMBLE_LEN - 1) : state == HDR ? CW'(HDR_LEN - 1) :
              state == PAY ? CW'(PAY_LEN - 1) : state == FCS ? CW'(FCS_LEN - 1) :
              state == IFG ? CW'(IFG_LEN - 2) : '0;
        start = armed && i_enable && i_fifo_count >= 12'(WORDS);
        nstate = state;
        ncnt = cnt + CW'(1);
        if (state == IDLE) begin
            ncnt = '0;
            nstate = start ? PRE : IDLE;
        end else if (cnt == lim) begin
            ncnt = '0;
            nstate = state == IFG ? IDLE : state_t'(state + 3'd1);
        end
        nbw = nstate == PAY && state == PAY ? (bw == 3'd5 ? 3'd0 : bw + 3'd1) : 3'd0;
        nbyte = nstate == PRE ? PREAMBLE_BYTE : nstate == SFD ? SFD_BYTE :
                nstate == HDR ? HDR_BYTES[111 - 8 * int'(ncnt) -: 8] :
                nstate == PAY ? i_fifo_dout[47 - 8 * int'(nbw) -: 8] :
                nstate == FCS ? ~crc[8 * int'(ncnt[1:0]) +: 8] : 8'h00;
        nerr = state != IDLE && (err || (nstate == PAY && i_fifo_empty));
        o_fifo_rd_en = nstate == PAY && nbw == 3'd5 && !i_fifo_empty;
    end

    always_ff @(posedge i_clk_125M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bw <= '0;
            armed <= 1'b0;
            err <= 1'b0;
            txd <= 8'h00;
            tx_en <= 1'b0;
            tx_er <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state <= nstate;
            cnt <= ncnt;
            bw <= nbw;
            armed <= 1'b1;
            err <= nerr;
            txd <= nbyte;
            tx_en <= nstate != IDLE && nstate != IFG;
            tx_er <= nerr && (nstate == PAY || nstate == FCS);
            if (nstate == FCS && ncnt == CW'(FCS_LEN - 1))
                o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

    assign o_busy = state != IDLE;

    crc32_d8 u_crc (
        .clk   (i_clk_125M),
        .rst_n (i_rst_n),
        .init  (state == IDLE),
        .calc  (nstate == HDR || nstate == PAY),
        .d     (nbyte),
        .crc   (crc)
    );
endmodule

// File: tb/tb_fifo2gmii48.sv
// tb_fifo2gmii48: FIFO model, frame capture and a byte-level Ethernet reference model for fifo2gmii48
`timescale 1ns/1ps
module tb_fifo2gmii48;
    import fifo2gmii48_pkg::*;
    localparam int WORDS = 8;
    localparam int FLEN = 26 + 6 * WORDS;
    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h0000_5E00_FACE;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic i_clk_125M = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_enable = 1'b0;
    logic [47:0] i_fifo_dout;
    logic i_fifo_empty;
    logic [11:0] i_fifo_count;
    logic o_fifo_rd_en, tx_en, tx_er, o_busy;
    logic [7:0] txd;
    logic [15:0] o_frame_cnt;

    fifo2gmii48 dut (
        .i_clk_125M   (i_clk_125M),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_fifo_dout  (i_fifo_dout),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_count (i_fifo_count),
        .o_fifo_rd_en (o_fifo_rd_en),
        .txd          (txd),
        .tx_en        (tx_en),
        .tx_er        (tx_er),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #4 i_clk_125M = ~i_clk_125M;

    typedef struct {
        int nw;
        bit en;
        int frames;
        int pops;
    } vec_t;

    vec_t vt[5];
    logic [47:0] q[$];
    logic [47:0] sh[$];
    logic [7:0] got[$];
    logic [7:0] expb[$];
    bit ger[$];
    bit force_empty;
    int pops, n_chk, n_fail;

    task automatic drive();
        i_fifo_empty = q.size() == 0 || force_empty;
        i_fifo_dout = q.size() > 0 ? q[0] : 48'hDEAD_BEEF_0BAD;
        i_fifo_count = 12'(q.size());
    endtask

    task automatic push(input logic [47:0] w);
        q.push_back(w);
        sh.push_back(w);
        drive();
    endtask

    task automatic push_rand(input int n);
        logic [47:0] w;
        repeat (n) begin
            w[47:16] = $urandom();
            w[15:0] = 16'($urandom());
            push(w);
        end
    endtask

    task automatic flush();
        q.delete();
        sh.delete();
        force_empty = 0;
        drive();
    endtask

    // FWFT FIFO: a pop requested during a cycle takes effect just after the following edge
    initial begin
        bit pend;
        drive();
        forever begin
            @(negedge i_clk_125M);
            #1;
            pend = o_fifo_rd_en;
            if (pend) pops++;
            @(posedge i_clk_125M);
            #1;
            if (pend && q.size() > 0) void'(q.pop_front());
            drive();
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Plain MSB-first CRC-32 fed with each byte's bits LSB first (wire order)
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ b[i];
            c = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
        end
        return c;
    endfunction

    task automatic build_exp();
        logic [111:0] hdr;
        logic [31:0] c, r;
        hdr = {DST, SRC, ETYPE};
        c = 32'hFFFF_FFFF;
        expb.delete();
        repeat (7) expb.push_back(8'h55);
        expb.push_back(8'hD5);
        for (int i = 0; i < 14; i++) expb.push_back(hdr[111 - 8 * i -: 8]);
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 6; b++) expb.push_back(sh[w][47 - 8 * b -: 8]);
        for (int i = 8; i < expb.size(); i++) c = crc_upd(c, expb[i]);
        for (int i = 0; i < 32; i++) r[i] = ~c[31 - i];
        for (int i = 0; i < 4; i++) expb.push_back(r[8 * i +: 8]);
    endtask

    // Called at a negedge; act 1 forces the FIFO empty, act 2 drops i_enable, after act_at bytes
    task automatic collect(input string tag, input int act_at, input int act, output int gap);
        int t;
        got.delete();
        ger.delete();
        t = 0;
        while (!tx_en && t < 400) begin
            @(negedge i_clk_125M);
            t++;
        end
        gap = t;
        if (!tx_en) begin
            chk({tag, " frame start"}, tx_en, 1);
            return;
        end
        t = 0;
        while (tx_en && t < 1000) begin
            got.push_back(txd);
            ger.push_back(tx_er);
            if (got.size() == act_at && act == 1) begin
                force_empty = 1;
                drive();
            end
            if (got.size() == act_at && act == 2) i_enable = 1'b0;
            @(negedge i_clk_125M);
            t++;
        end
        if (tx_en) chk({tag, " frame end"}, tx_en, 0);
    endtask

    task automatic check_frame(input string tag);
        int mi, ne;
        mi = -1;
        ne = 0;
        build_exp();
        chk({tag, " length"}, got.size(), FLEN);
        foreach (expb[i]) if (mi < 0 && (i >= got.size() || got[i] !== expb[i])) mi = i;
        chk({tag, " first bad byte index"}, mi, -1);
        foreach (ger[i]) if (ger[i]) ne++;
        chk({tag, " tx_er cycles"}, ne, 0);
        repeat (WORDS) void'(sh.pop_front());
    endtask

    task automatic quiet(input string tag, input int n);
        int hi;
        hi = 0;
        repeat (n) begin
            @(negedge i_clk_125M);
            if (tx_en) hi++;
        end
        chk({tag, " unexpected tx_en cycles"}, hi, 0);
    endtask

    initial begin
        int gap, p0, f0, t, mi, ne;
        logic [31:0] c;
        vt[0] = '{7, 1'b1, 0, 0};
        vt[1] = '{8, 1'b0, 0, 0};
        vt[2] = '{8, 1'b1, 1, 8};
        vt[3] = '{12, 1'b1, 1, 8};
        vt[4] = '{16, 1'b1, 2, 16};

        // Reset with a full FIFO and permission already granted
        i_enable = 1'b1;
        for (int k = 0; k < 8; k++) push({12'd0, 12'(k), 24'hA0B0C0 + 24'(k)});
        repeat (3) @(negedge i_clk_125M);
        chk("reset txd", txd, 0);
        chk("reset tx_en", tx_en, 0);
        chk("reset tx_er", tx_er, 0);
        chk("reset rd_en", o_fifo_rd_en, 0);
        chk("reset busy", o_busy, 0);
        chk("reset frame_cnt", o_frame_cnt, 0);
        chk("reset crc", dut.u_crc.crc, 32'hFFFF_FFFF);
        i_rst_n = 1'b1;
        @(negedge i_clk_125M);
        chk("first edge after reset tx_en", tx_en, 0);

        // Scenario 1/2: known payload, residue and FCS
        p0 = pops;
        collect("s1", -1, 0, gap);
        chk("s1 word0", {got[22], got[23], got[24], got[25], got[26], got[27]}, 48'h0000_00A0_B0C0);
        chk("s1 word7", {got[64], got[65], got[66], got[67], got[68], got[69]}, 48'h0000_07A0_B0C7);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < got.size(); i++) c = crc_upd(c, got[i]);
        chk("s2 crc residue", c, CRC_RESIDUE);
        check_frame("s1");
        chk("s2 fcs", {got[70], got[71], got[72], got[73]}, {expb[70], expb[71], expb[72], expb[73]});
        quiet("s1", 30);
        chk("s1 pops", pops - p0, 8);
        chk("s1 frame_cnt", o_frame_cnt, 1);

        // Scenario 3: one word short, then the last word arrives
        p0 = pops;
        push_rand(7);
        quiet("s3 short", 40);
        chk("s3 short pops", pops - p0, 0);
        push_rand(1);
        @(negedge i_clk_125M);
        chk("s3 start latency", tx_en, 1);
        collect("s3", -1, 0, gap);
        check_frame("s3");
        quiet("s3", 30);
        chk("s3 frame_cnt", o_frame_cnt, 2);

        // Scenario 4: three back-to-back frames
        p0 = pops;
        f0 = o_frame_cnt;
        push_rand(24);
        for (int f = 0; f < 3; f++) begin
            collect("s4", -1, 0, gap);
            if (f > 0) chk($sformatf("s4 gap %0d", f), gap, 12);
            check_frame($sformatf("s4 frame %0d", f));
        end
        quiet("s4", 40);
        chk("s4 frames", o_frame_cnt - f0, 3);
        chk("s4 pops", pops - p0, 24);

        // Table: queue depth and permission versus frames produced
        foreach (vt[v]) begin
            p0 = pops;
            f0 = o_frame_cnt;
            i_enable = vt[v].en;
            push_rand(vt[v].nw);
            for (int f = 0; f < vt[v].frames; f++) begin
                collect($sformatf("vec%0d", v), -1, 0, gap);
                check_frame($sformatf("vec%0d frame %0d", v, f));
            end
            quiet($sformatf("vec%0d", v), 60);
            chk($sformatf("vec%0d pops", v), pops - p0, vt[v].pops);
            chk($sformatf("vec%0d frames", v), o_frame_cnt - f0, vt[v].frames);
            flush();
        end

        // Permission withdrawn mid-frame: frame completes, nothing follows
        p0 = pops;
        f0 = o_frame_cnt;
        i_enable = 1'b1;
        push_rand(16);
        collect("enoff", 30, 2, gap);
        check_frame("enoff");
        quiet("enoff", 100);
        chk("enoff frames", o_frame_cnt - f0, 1);
        chk("enoff pops", pops - p0, 8);
        flush();

        // Scenario 5: underrun at payload byte 20
        p0 = pops;
        f0 = o_frame_cnt;
        i_enable = 1'b1;
        push_rand(8);
        collect("s5", 42, 1, gap);
        chk("s5 length", got.size(), FLEN);
        mi = -1;
        ne = 0;
        foreach (ger[i]) begin
            if (ger[i]) ne++;
            if (mi < 0 && ger[i] != (i >= 42)) mi = i;
        end
        chk("s5 tx_er bad index", mi, -1);
        chk("s5 tx_er cycles", ne, 32);
        quiet("s5", 40);
        chk("s5 pops", pops - p0, 3);
        chk("s5 frames", o_frame_cnt - f0, 1);
        flush();

        // Scenario 6: reset during the header
        p0 = pops;
        push_rand(8);
        t = 0;
        while (!tx_en && t < 400) begin
            @(negedge i_clk_125M);
            t++;
        end
        chk("s6 start", tx_en, 1);
        repeat (13) @(negedge i_clk_125M);
        chk("s6 busy in header", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("s6 reset tx_en", tx_en, 0);
        chk("s6 reset txd", txd, 0);
        chk("s6 reset busy", o_busy, 0);
        chk("s6 reset frame_cnt", o_frame_cnt, 0);
        @(negedge i_clk_125M);
        i_rst_n = 1'b1;
        @(negedge i_clk_125M);
        chk("s6 first edge tx_en", tx_en, 0);
        collect("s6", -1, 0, gap);
        check_frame("s6");
        quiet("s6", 30);
        chk("s6 frame_cnt", o_frame_cnt, 1);
        chk("s6 pops", pops - p0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
